// File: rtl/lcd_cmd_sequencer.sv
// Character-LCD command sequencer: HD44780 power-on init, then valid/ready
// requests turned into timed nCS/nWR write cycles followed by busy-flag polls.
module lcd_cmd_sequencer #(
    parameter int PWRUP_CYC = 750000,
    parameter int CYC_HOLD  = 16,
    parameter int GAP_CYC   = 2,
    parameter int POLL_MAX  = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic       timeout_err,
    output logic       nCS,
    output logic       nWR,
    output logic       nRD,
    output logic       RS,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [7:0] db_in
);

    localparam int PWR_W  = $clog2(PWRUP_CYC + 1);
    localparam int CYC_MX = (CYC_HOLD > GAP_CYC) ? CYC_HOLD : GAP_CYC;
    localparam int CYC_W  = $clog2(CYC_MX + 1);
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        PWRUP, INIT_LOAD, WR, WR_GAP, RD, RD_GAP, IDLE
    } state_t;

    state_t            state, stateNxt;
    logic [PWR_W-1:0]  pwrCnt, pwrCntNxt;
    logic [CYC_W-1:0]  cycCnt, cycCntNxt;
    logic [POLL_W-1:0] pollCnt, pollCntNxt;
    logic [1:0]        initIdx, initIdxNxt;
    logic              rsLat, rsLatNxt;
    logic [7:0]        dataLat, dataLatNxt;
    logic              bfLat, bfLatNxt;
    logic              initDoneNxt, timeoutNxt;
    logic              wrPhase, wrGapPhase, rdPhase;

    // Only the busy flag is consumed; the address counter bits are ignored.
    logic unusedDbIn;
    assign unusedDbIn = ^db_in[6:0];

    function automatic logic [7:0] initRom(input logic [1:0] idx);
        case (idx)
            2'd0:    initRom = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    initRom = 8'h0C;   // display on, cursor off
            2'd2:    initRom = 8'h01;   // clear display
            default: initRom = 8'h06;   // entry mode: increment, no shift
        endcase
    endfunction

    // Next-state, counter and latch logic for the bus-cycle sequence.
    always_comb begin
        stateNxt    = state;
        pwrCntNxt   = pwrCnt;
        cycCntNxt   = cycCnt;
        pollCntNxt  = pollCnt;
        initIdxNxt  = initIdx;
        rsLatNxt    = rsLat;
        dataLatNxt  = dataLat;
        bfLatNxt    = bfLat;
        initDoneNxt = init_done;
        timeoutNxt  = timeout_err;
        case (state)
            PWRUP: begin
                if (pwrCnt == PWR_W'(PWRUP_CYC - 1)) begin
                    stateNxt   = INIT_LOAD;
                    initIdxNxt = 2'd0;
                    pwrCntNxt  = '0;
                end else begin
                    pwrCntNxt = pwrCnt + PWR_W'(1);
                end
            end
            INIT_LOAD: begin
                rsLatNxt   = 1'b0;
                dataLatNxt = initRom(initIdx);
                cycCntNxt  = '0;
                stateNxt   = WR;
            end
            WR: begin
                if (cycCnt == CYC_W'(CYC_HOLD - 1)) begin
                    stateNxt  = WR_GAP;
                    cycCntNxt = '0;
                end else begin
                    cycCntNxt = cycCnt + CYC_W'(1);
                end
            end
            WR_GAP: begin
                pollCntNxt = '0;
                if (cycCnt == CYC_W'(GAP_CYC - 1)) begin
                    stateNxt  = RD;
                    cycCntNxt = '0;
                end else begin
                    cycCntNxt = cycCnt + CYC_W'(1);
                end
            end
            RD: begin
                if (cycCnt == CYC_W'(CYC_HOLD - 1)) begin
                    bfLatNxt  = db_in[7];
                    stateNxt  = RD_GAP;
                    cycCntNxt = '0;
                end else begin
                    cycCntNxt = cycCnt + CYC_W'(1);
                end
            end
            RD_GAP: begin
                if (cycCnt == CYC_W'(GAP_CYC - 1)) begin
                    cycCntNxt = '0;
                    if (!bfLat) begin
                        if (init_done) begin
                            stateNxt = IDLE;
                        end else if (initIdx == 2'd3) begin
                            initDoneNxt = 1'b1;
                            stateNxt    = IDLE;
                        end else begin
                            initIdxNxt = initIdx + 2'd1;
                            stateNxt   = INIT_LOAD;
                        end
                    end else begin
                        pollCntNxt = pollCnt + POLL_W'(1);
                        if (pollCnt == POLL_W'(POLL_MAX - 1)) begin
                            timeoutNxt = 1'b1;
                            stateNxt   = IDLE;
                        end else begin
                            stateNxt = RD;
                        end
                    end
                end else begin
                    cycCntNxt = cycCnt + CYC_W'(1);
                end
            end
            IDLE: begin
                // req_ready is registered and already folds in init_done/timeout_err
                if (req_valid && req_ready) begin
                    rsLatNxt   = req_rs;
                    dataLatNxt = req_data;
                    cycCntNxt  = '0;
                    stateNxt   = WR;
                end
            end
            default: stateNxt = PWRUP;
        endcase
    end

    // State, counters and request latches; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PWRUP;
            pwrCnt      <= '0;
            cycCnt      <= '0;
            pollCnt     <= '0;
            initIdx     <= 2'd0;
            rsLat       <= 1'b0;
            dataLat     <= 8'h00;
            bfLat       <= 1'b0;
            init_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= stateNxt;
            pwrCnt      <= pwrCntNxt;
            cycCnt      <= cycCntNxt;
            pollCnt     <= pollCntNxt;
            initIdx     <= initIdxNxt;
            rsLat       <= rsLatNxt;
            dataLat     <= dataLatNxt;
            bfLat       <= bfLatNxt;
            init_done   <= initDoneNxt;
            timeout_err <= timeoutNxt;
        end
    end

    // Outputs are decoded from the next state so every pin is a flop that
    // switches on the same edge as the state it belongs to.
    assign wrPhase    = (stateNxt == WR);
    assign wrGapPhase = (stateNxt == WR_GAP);
    assign rdPhase    = (stateNxt == RD);

    // Registered bus strobes, data and handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nCS       <= 1'b1;
            nWR       <= 1'b1;
            nRD       <= 1'b1;
            RS        <= 1'b0;
            db_out    <= 8'h00;
            db_oe     <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            nCS       <= !(wrPhase || rdPhase);
            nWR       <= !wrPhase;
            nRD       <= !rdPhase;
            // RS and data are held through the write gap for LCD hold time
            RS        <= (wrPhase || wrGapPhase) ? rsLatNxt : 1'b0;
            db_out    <= (wrPhase || wrGapPhase) ? dataLatNxt : 8'h00;
            db_oe     <= wrPhase || (wrGapPhase && (cycCntNxt == '0));
            req_ready <= (stateNxt == IDLE) && initDoneNxt && !timeoutNxt;
            busy      <= (stateNxt != IDLE);
        end
    end

endmodule
